// File: rtl/bsg_dmc_burst_master.sv
// bsg_dmc_burst_master
// Splits one cache-line request into DMC UI beats. A write line is streamed
// over the write-data FIFO and then followed by a single WRITE command. A read
// line is requested with one READ command, and the returned beats are
// gathered into a line buffer that is then offered on the response port.
// Optional feature: define BSG_DMC_BURST_MASTER_TIMEOUT_EN to add a read-data
// watchdog and the sticky timeout_o output.
module bsg_dmc_burst_master #(
    parameter int ui_addr_width_p    = 28,
    parameter int ui_data_width_p    = 32,
    parameter int burst_data_width_p = 128,
    parameter int timeout_cycles_p   = 1024
) (
    input  logic                            ui_clk_i,
    input  logic                            ui_rst_n_i,

    input  logic                            req_v_i,
    output logic                            req_ready_o,
    input  logic                            req_write_i,
    input  logic [ui_addr_width_p-1:0]      req_addr_i,
    input  logic [burst_data_width_p-1:0]   req_data_i,
    input  logic [burst_data_width_p/8-1:0] req_mask_i,

    output logic                            resp_v_o,
    input  logic                            resp_yumi_i,
    output logic [burst_data_width_p-1:0]   resp_data_o,

    output logic [ui_addr_width_p-1:0]      app_addr_o,
    output logic [2:0]                      app_cmd_o,
    output logic                            app_en_o,
    input  logic                            app_rdy_i,
    output logic                            app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]      app_wdf_data_o,
    output logic [ui_data_width_p/8-1:0]    app_wdf_mask_o,
    output logic                            app_wdf_end_o,
    input  logic                            app_wdf_rdy_i,
    input  logic                            app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]      app_rd_data_i,
    input  logic                            app_rd_data_end_i,

    output logic                            busy_o
`ifdef BSG_DMC_BURST_MASTER_TIMEOUT_EN
    ,
    output logic                            timeout_o
`endif
);

    localparam int beats_lp      = burst_data_width_p / ui_data_width_p;
    localparam int cnt_width_lp  = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int mask_width_lp = ui_data_width_p / 8;

    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(beats_lp - 1);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);

    // DMC UI command encoding
    localparam logic [2:0] cmd_write_lp = 3'b000;
    localparam logic [2:0] cmd_read_lp  = 3'b001;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_CMD  = 3'd2,
        RD_CMD  = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_e;

    state_e                          state_reg, state_next;
    logic [cnt_width_lp-1:0]         cnt_reg, cnt_next;

    logic [ui_addr_width_p-1:0]      addr_reg;
    logic [burst_data_width_p-1:0]   data_reg;
    logic [burst_data_width_p/8-1:0] mask_reg;

    logic [ui_data_width_p-1:0]      wr_data_beats [beats_lp];
    logic [mask_width_lp-1:0]        wr_mask_beats [beats_lp];
    logic [ui_data_width_p-1:0]      rd_buf_reg    [beats_lp];
    logic                            rd_we;
    logic                            wd_expired;

    // Slice the captured write line into beats and assemble the read line
    genvar gi;
    generate
        for (gi = 0; gi < beats_lp; gi++) begin : g_beat
            assign wr_data_beats[gi] = data_reg[gi*ui_data_width_p +: ui_data_width_p];
            assign wr_mask_beats[gi] = mask_reg[gi*mask_width_lp +: mask_width_lp];
            assign resp_data_o[gi*ui_data_width_p +: ui_data_width_p] = rd_buf_reg[gi];
        end
    endgenerate

    assign app_addr_o     = addr_reg;
    assign app_wdf_data_o = wr_data_beats[cnt_reg];
    assign app_wdf_mask_o = wr_mask_beats[cnt_reg];
    assign busy_o         = (state_reg != IDLE);

`ifdef BSG_DMC_BURST_MASTER_TIMEOUT_EN
    localparam int wd_width_lp = $clog2(timeout_cycles_p + 1);

    logic [wd_width_lp-1:0] wd_reg, wd_next;
    logic                   timeout_reg;

    // The watchdog fires on the idle cycle that would complete the limit
    assign wd_expired = (state_reg == RD_DATA) && !app_rd_data_valid_i &&
                        (wd_reg == wd_width_lp'(timeout_cycles_p - 1));
    assign timeout_o  = timeout_reg;

    // Count consecutive RD_DATA cycles without a returned beat
    always_comb begin
        wd_next = '0;
        if (state_reg == RD_DATA && !app_rd_data_valid_i) begin
            wd_next = wd_reg + 1'b1;
        end
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge ui_clk_i or negedge ui_rst_n_i) begin
        if (!ui_rst_n_i) begin
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wd_reg      <= wd_next;
            timeout_reg <= timeout_reg | wd_expired;
        end
    end
`else
    localparam int unused_timeout_cycles_lp = timeout_cycles_p;
    assign wd_expired = 1'b0;
`endif

    // State and beat counter
    always_ff @(posedge ui_clk_i or negedge ui_rst_n_i) begin
        if (!ui_rst_n_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        req_ready_o    = 1'b0;
        resp_v_o       = 1'b0;
        app_en_o       = 1'b0;
        app_cmd_o      = cmd_write_lp;
        app_wdf_wren_o = 1'b0;
        app_wdf_end_o  = 1'b0;
        rd_we          = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_v_i) begin
                    cnt_next   = '0;
                    state_next = req_write_i ? WR_DATA : RD_CMD;
                end
            end
            WR_DATA: begin
                app_wdf_wren_o = 1'b1;
                app_wdf_end_o  = (cnt_reg == last_cnt_lp);
                if (app_wdf_rdy_i) begin
                    if (cnt_reg == last_cnt_lp) begin
                        cnt_next   = '0;
                        state_next = WR_CMD;
                    end else begin
                        cnt_next = cnt_reg + cnt_one_lp;
                    end
                end
            end
            WR_CMD: begin
                app_en_o  = 1'b1;
                app_cmd_o = cmd_write_lp;
                if (app_rdy_i) begin
                    state_next = IDLE;
                end
            end
            RD_CMD: begin
                app_en_o  = 1'b1;
                app_cmd_o = cmd_read_lp;
                if (app_rdy_i) begin
                    cnt_next   = '0;
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (app_rd_data_valid_i) begin
                    rd_we    = 1'b1;
                    cnt_next = cnt_reg + cnt_one_lp;
                    if (cnt_reg == last_cnt_lp || app_rd_data_end_i) begin
                        state_next = RESP;
                    end
                end else if (wd_expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_v_o = 1'b1;
                if (resp_yumi_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture; datapath registers carry no reset
    always_ff @(posedge ui_clk_i) begin
        if (req_v_i && req_ready_o) begin
            addr_reg <= req_addr_i;
            data_reg <= req_data_i;
            mask_reg <= req_mask_i;
        end
    end

    // Read line buffer; slices not returned keep their old contents
    always_ff @(posedge ui_clk_i) begin
        if (rd_we) begin
            rd_buf_reg[cnt_reg] <= app_rd_data_i;
        end
    end

endmodule

// File: tb/tb_bsg_dmc_burst_master.sv
// Testbench for bsg_dmc_burst_master (32-bit beats, 128-bit lines).
// Build with BSG_DMC_BURST_MASTER_TIMEOUT_EN defined to also exercise the
// read-data watchdog.
module tb_bsg_dmc_burst_master;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_v, req_ready, req_write;
    logic [27:0]  req_addr;
    logic [127:0] req_data;
    logic [15:0]  req_mask;
    logic         resp_v, yumi;
    logic [127:0] resp_data;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy;
    logic         wdf_wren, wdf_end, wdf_rdy;
    logic [31:0]  wdf_data;
    logic [3:0]   wdf_mask;
    logic         rvalid, rend;
    logic [31:0]  rdata;
    logic         busy;
`ifdef BSG_DMC_BURST_MASTER_TIMEOUT_EN
    logic         timeout;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference view of the DUT's read line buffer, one word per slice
    logic [31:0] model_buf [4];

    always #5 clk = ~clk;

    bsg_dmc_burst_master #(
        .ui_addr_width_p(28), .ui_data_width_p(32),
        .burst_data_width_p(128), .timeout_cycles_p(16)
    ) dut (
        .ui_clk_i(clk), .ui_rst_n_i(rst_n),
        .req_v_i(req_v), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask),
        .resp_v_o(resp_v), .resp_yumi_i(yumi), .resp_data_o(resp_data),
        .app_addr_o(app_addr), .app_cmd_o(app_cmd), .app_en_o(app_en),
        .app_rdy_i(app_rdy), .app_wdf_wren_o(wdf_wren), .app_wdf_data_o(wdf_data),
        .app_wdf_mask_o(wdf_mask), .app_wdf_end_o(wdf_end), .app_wdf_rdy_i(wdf_rdy),
        .app_rd_data_valid_i(rvalid), .app_rd_data_i(rdata),
        .app_rd_data_end_i(rend), .busy_o(busy)
`ifdef BSG_DMC_BURST_MASTER_TIMEOUT_EN
        , .timeout_o(timeout)
`endif
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_line();
        return {model_buf[3], model_buf[2], model_buf[1], model_buf[0]};
    endfunction

    // Called at a negedge; waits (bounded) until the DUT can take a request
    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check_val("req_ready_wait", 0, 1);
    endtask

    // mode 0: wdf always ready, 1: wdf low on WR_DATA cycles 2-3, 2: random
    task automatic do_write(input logic [27:0] a, input logic [127:0] d,
                            input logic [15:0] m, input int mode);
        int beats = 0, cyc = 0, first = -1, last = -1, wren_cycles = 0;
        bit cmd_done = 0;
        wait_ready();
        req_v = 1; req_write = 1; req_addr = a; req_data = d; req_mask = m;
        @(negedge clk);
        req_v = 0;
        while (!cmd_done && cyc < 300) begin
            case (mode)
                0:       wdf_rdy = 1'b1;
                1:       wdf_rdy = !(wren_cycles == 1 || wren_cycles == 2);
                default: wdf_rdy = ($urandom_range(0, 1) == 1);
            endcase
            app_rdy = ($urandom_range(0, 1) == 1);
            #1;
            if (wdf_wren) begin
                check_val("wr_beat_data", wdf_data, d[beats*32 +: 32]);
                check_val("wr_beat_mask", wdf_mask, m[beats*4 +: 4]);
                check_val("wr_beat_end", wdf_end, beats == 3);
                if (wdf_rdy) begin
                    if (beats == 0) first = cyc;
                    last = cyc;
                    beats++;
                end
                wren_cycles++;
            end
            if (app_en && app_rdy) begin
                check_val("wr_cmd", app_cmd, CMD_WRITE);
                check_val("wr_cmd_addr", app_addr, a);
                check_val("wr_beats_before_cmd", beats, 4);
                cmd_done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        wdf_rdy = 0; app_rdy = 0;
        check_val("wr_cmd_done", cmd_done, 1);
        if (mode == 0) check_val("wr_consecutive", last - first, 3);
        if (mode == 1) check_val("wr_stall_cycles", wren_cycles, 6);
        check_val("wr_idle_busy", busy, 0);
        check_val("wr_idle_ready", req_ready, 1);
        $display("write addr=%h data=%h mask=%h mode=%0d beats=%0d", a, d, m, mode, beats);
    endtask

    // rdy_delay>0: app_rdy held low that many cycles then high; 0: random.
    // exp_gap: cycles from last returned beat to resp_v (0 = unchecked).
    task automatic do_read(input logic [27:0] a, input int nbeats, input bit use_end,
                           input int hold, input int rdy_delay, input int exp_gap);
        int k = 0, cyc = 0, cmds = 0, gapc = 0, last_beat = 0;
        bit cmd_ok = 0;
        wait_ready();
        req_v = 1; req_write = 0; req_addr = a;
        @(negedge clk);
        req_v = 0;
        while (!resp_v && cyc < 400) begin
            rvalid = 0; rend = 0; rdata = $urandom;
            if (!cmd_ok) begin
                if (rdy_delay > 0) app_rdy = (cyc >= rdy_delay);
                else               app_rdy = ($urandom_range(0, 1) == 1);
                rvalid = ($urandom_range(0, 3) == 0);   // must be ignored
            end else if (k < nbeats) begin
                app_rdy = 0;
                rvalid  = ($urandom_range(0, 2) != 0) || gapc >= 3;
                if (rvalid) begin
                    model_buf[k] = rdata;
                    rend = use_end && (k == nbeats - 1);
                    k++;
                    gapc = 0;
                    last_beat = cyc;
                end else begin
                    gapc++;
                end
            end else begin
                app_rdy = 0;
            end
            #1;
            if (app_en) begin
                if (cmd_ok) check_val("rd_extra_cmd", app_en, 0);
                else if (app_rdy) begin
                    check_val("rd_cmd", app_cmd, CMD_READ);
                    check_val("rd_cmd_addr", app_addr, a);
                    cmd_ok = 1;
                    cmds++;
                end
            end
            check_val("rd_no_wren", wdf_wren, 0);
            @(negedge clk);
            cyc++;
        end
        rvalid = 0; rend = 0; app_rdy = 0;
        check_val("rd_cmd_count", cmds, 1);
        check_val("rd_resp_v", resp_v, 1);
        check_val("rd_resp_data", resp_data, model_line());
        if (exp_gap > 0) check_val("rd_resp_latency", cyc - last_beat, exp_gap);
        for (int h = 0; h < hold; h++) begin
            yumi = 0;
            @(negedge clk);
            check_val("rd_resp_hold_v", resp_v, 1);
            check_val("rd_resp_hold_data", resp_data, model_line());
        end
        yumi = 1;
        @(negedge clk);
        yumi = 0;
        check_val("rd_after_yumi_v", resp_v, 0);
        check_val("rd_after_yumi_ready", req_ready, 1);
        $display("read addr=%h beats=%0d end=%0d hold=%0d line=%h", a, nbeats, use_end, hold, model_line());
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, req_ready, 1);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_resp_v"}, resp_v, 0);
        check_val({tag, "_app_en"}, app_en, 0);
        check_val({tag, "_wren"}, wdf_wren, 0);
        check_val({tag, "_wdf_end"}, wdf_end, 0);
`ifdef BSG_DMC_BURST_MASTER_TIMEOUT_EN
        check_val({tag, "_timeout"}, timeout, 0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit got=1 exp=0");
        $fatal(1, "time limit");
    end

    initial begin
        logic [127:0] d;
        rst_n = 0; req_v = 0; req_write = 0; req_addr = '0; req_data = '0; req_mask = '0;
        yumi = 0; app_rdy = 0; wdf_rdy = 0; rvalid = 0; rdata = '0; rend = 0;
        for (int i = 0; i < 4; i++) model_buf[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        $display("reset checked");
        rst_n = 1;
        @(negedge clk);

        // Directed write, always ready, then with a two-cycle wdf stall
        do_write(28'h100, {32'h4444, 32'h3333, 32'h2222, 32'h1111}, 16'h0000, 0);
        do_write(28'h100, {32'h4444, 32'h3333, 32'h2222, 32'h1111}, 16'h0000, 1);

        // Directed read: command stalled 5 cycles, four beats, held response
        do_read(28'h200, 4, 1, 3, 5, 1);

        // Read with immediate yumi followed straight away by a write
        do_read(28'h240, 4, 0, 0, 0, 1);
        do_write(28'h280, {$urandom, $urandom, $urandom, $urandom}, 16'h0f0f, 2);

        // Reset in the middle of a write burst, then a normal read
        d = {$urandom, $urandom, $urandom, $urandom};
        wait_ready();
        req_v = 1; req_write = 1; req_addr = 28'h300; req_data = d; req_mask = '0;
        @(negedge clk);
        req_v = 0; wdf_rdy = 1;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_mid_beat2", wdf_data, d[64 +: 32]);
        rst_n = 0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst_n = 1; wdf_rdy = 0;
        @(negedge clk);
        check_val("rst_release_ready", req_ready, 1);
        $display("reset during write burst checked");
        do_read(28'h340, 4, 1, 1, 0, 1);

        // Randomized mix of writes and reads, including early-ended reads
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write(28'($urandom), {$urandom, $urandom, $urandom, $urandom},
                         16'($urandom), 2);
            end else begin
                int nb = $urandom_range(1, 4);
                bit ue = (nb < 4) ? 1'b1 : 1'($urandom_range(0, 1));
                do_read(28'($urandom), nb, ue, $urandom_range(0, 3), 0, 1);
            end
        end

`ifdef BSG_DMC_BURST_MASTER_TIMEOUT_EN
        // Only two beats and no end flag: watchdog must release the line
        check_val("wd_timeout_before", timeout, 0);
        do_read(28'h400, 2, 0, 1, 0, 17);
        check_val("wd_timeout_sticky", timeout, 1);
        rst_n = 0;
        @(negedge clk);
        check_reset_outputs("wd_reset");
        rst_n = 1;
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
